// File: rtl/mem_pkg.sv
// Shared definitions for the data-port memory responder.
//   mem_state_t  : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES   : bytes per array word
//   FAULT_*      : fault codes, reserved for the CPU's exception logic
//   fault_classify() : maps a byte address to a fault code
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    // Misalignment takes priority over out-of-range when both apply.
    function automatic logic [1:0] fault_classify(input logic [31:0] addr,
                                                  input int unsigned addr_w);
        logic [1:0] code;
        code = FAULT_NONE;
        if (addr[1:0] != 2'b00) begin
            code = FAULT_MISALIGN;
        end else if ((addr >> (addr_w + 2)) != 32'd0) begin
            code = FAULT_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// CPU data-port bus between the core (master) and the memory responder (slave).
//   req/we/addr/wdata/be : request, driven by the master
//   ready/rdata/err      : one-cycle response, driven by the slave
interface data_mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, err
    );
endinterface

// File: rtl/mem_word_array.sv
// Word storage for the data memory responder.
//   clk      : write clock
//   wr_en    : commit a write this edge
//   wr_idx   : word index written
//   wr_data  : write data
//   wr_be    : per-byte write enables, wr_be[0] -> bits 7:0
//   rd_idx   : word index read
//   rd_data  : combinational read data
// Contents are not reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // One independent byte lane per enable bit, so partial stores never
    // need a read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port.
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : data_mem_if slave port (req/we/addr/wdata/be in,
//            ready/rdata/err out)
// Accepts one request in IDLE, waits WAIT_CYCLES cycles, then pulses ready
// for one cycle with load data or an error flag. Stores commit on the edge
// that ends RESP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mem_state_t  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        armed_reg;

    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;

    logic        ready_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        eff_we;
    logic [31:0] eff_addr;
    logic        fault;
    logic        wr_en;
    logic [31:0] rd_data;

    // The request driving the response is the live bus while in IDLE (needed
    // for the zero-wait path, where RESP is entered on the accept edge) and
    // the latched copy afterwards.
    assign eff_we   = (state_reg == IDLE) ? bus.we   : we_reg;
    assign eff_addr = (state_reg == IDLE) ? bus.addr : addr_reg;
    assign fault    = (fault_classify(eff_addr, ADDR_W) != FAULT_NONE);

    // In RESP eff_addr is the latched address, so the fault gate applies
    // to the latched request.
    assign wr_en    = (state_reg == RESP) && we_reg && !fault;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // armed_reg blocks acceptance on the first edge after reset
                // release.
                if (armed_reg && bus.req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            armed_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            be_reg    <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= 1'b1;
            if (accept) begin
                we_reg    <= bus.we;
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
                be_reg    <= bus.be;
            end
        end
    end

    // Response registers load on the edge entering RESP; rdata/err then hold
    // until the next response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_reg <= 1'b0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (state_next == RESP && state_reg != RESP) begin
            ready_reg <= 1'b1;
            err_reg   <= fault;
            rdata_reg <= (fault || eff_we) ? 32'd0 : rd_data;
        end else begin
            ready_reg <= 1'b0;
        end
    end

    mem_word_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (addr_reg[ADDR_W+1:2]),
        .wr_data (wdata_reg),
        .wr_be   (be_reg),
        .rd_idx  (eff_addr[ADDR_W+1:2]),
        .rd_data (rd_data)
    );

    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int W2     = 2;

    logic clk;
    logic reset;
    int   cyc;

    data_mem_if bus2 ();
    data_mem_if bus0 ();

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bit          chk_rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [int];

    // Response monitor for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus2.ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {31'd0, bus2.ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn: resp cyc=%0d rdata=%h err=%b", cyc, bus2.rdata, bus2.err);
                check("latency", 32'(cyc), 32'(e.exp_cyc));
                check("err", {31'd0, bus2.err}, {31'd0, e.exp_err});
                if (e.chk_rdata) check("rdata", bus2.rdata, e.exp_rdata);
            end
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            check("response_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        logic f;
        int   idx;
        @(negedge clk);
        bus2.req   = 1'b1;
        bus2.we    = we;
        bus2.addr  = addr;
        bus2.wdata = wdata;
        bus2.be    = be;
        f   = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
        idx = int'(addr[ADDR_W+1:2]);
        e.exp_cyc   = cyc + W2 + 1;
        e.exp_err   = f;
        e.exp_rdata = 32'd0;
        e.chk_rdata = 1'b0;
        if (f) begin
            e.chk_rdata = 1'b1;
        end else if (!we && model.exists(idx)) begin
            e.chk_rdata = 1'b1;
            e.exp_rdata = model[idx];
        end else if (we) begin
            logic [31:0] w;
            w = model.exists(idx) ? model[idx] : 32'd0;
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            model[idx] = w;
        end
        sb_q.push_back(e);
        $display("txn: issue we=%b addr=%h wdata=%h be=%b", we, addr, wdata, be);
        @(posedge clk);
        #1;
        // Scramble the bus after accept: the responder must use latched values.
        bus2.req   = 1'b0;
        bus2.we    = ~we;
        bus2.addr  = $urandom;
        bus2.wdata = $urandom;
        bus2.be    = 4'($urandom);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 32'd0; bus2.wdata = 32'd0; bus2.be = 4'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0; bus0.be = 4'd0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset defaults held over 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {31'd0, bus2.ready}, 32'd0);
            check("rst_rdata", bus2.rdata, 32'd0);
            check("rst_err",   {31'd0, bus2.err},   32'd0);
            check("rst_ready0", {31'd0, bus0.ready}, 32'd0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Full store then load.
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        do_txn(1'b0, 32'h10, 32'h0, 4'b0000);
        // Partial store: expect 0xDEAABE55.
        do_txn(1'b1, 32'h10, 32'h00AA0055, 4'b0101);
        do_txn(1'b0, 32'h10, 32'h0, 4'b0000);
        check("partial_model", model[4], 32'hDEAABE55);
        // Empty byte enable: legal, no write.
        do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        do_txn(1'b0, 32'h10, 32'h0, 4'b1111);
        // Faults.
        do_txn(1'b0, 32'h13, 32'h0, 4'b0000);
        do_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111);
        do_txn(1'b1, 32'h1000, 32'h55555555, 4'b1111);
        do_txn(1'b0, 32'h0, 32'h0, 4'b0000);
        do_txn(1'b0, 32'h1010, 32'h0, 4'b0000);

        // Zero wait states: req held high for 6 edges -> 1,0,1,0,1,0.
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h40; bus0.be = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            $display("txn: zero-wait cyc=%0d ready=%b err=%b", cyc, bus0.ready, bus0.err);
            check("zw_ready", {31'd0, bus0.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus0.ready) check("zw_err", {31'd0, bus0.err}, 32'd0);
        end
        bus0.req = 1'b0;

        // Reset mid-store aborts the write.
        do_txn(1'b1, 32'h20, 32'h11111111, 4'b1111);
        @(negedge clk);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h20;
        bus2.wdata = 32'h12345678; bus2.be = 4'b1111;
        $display("txn: issue aborted store addr=00000020 wdata=12345678");
        @(posedge clk);
        #1 bus2.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_reset_ready", {31'd0, bus2.ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_ready", {31'd0, bus2.ready}, 32'd0);
        end
        do_txn(1'b0, 32'h20, 32'h0, 4'b0000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
